adder_share_arbiter: RTL and testbench

- Shares one 32-bit combinational Adder instance among NUM_REQ requesters, e.g. PC+4, branch-target and a spare slot.
- Each requester raises a valid/ready request carrying two operands.
- A round-robin arbiter grants one request per cycle and drives the shared adder.
- The sum is captured in a one-entry output register tagged with the requester id, under consumer backpressure.
- Sits between IF/ID address-generation logic and the pipeline registers that consume computed addresses.

---
 rtl/adder_share_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//
// Purpose:
//   Lets several address-generation requesters (PC+4, branch target, a spare
//   slot, ...) share one WIDTH-bit combinational adder. A round-robin arbiter
//   picks one valid request per cycle, feeds its operands to the shared
//   Adder, and the sum is captured in a one-entry output register tagged with
//   the id of the requester that produced it. The output register supports
//   consumer backpressure and same-cycle drain/refill.
//
// Ports:
//   Clk        in   1              rising-edge clock for all state
//   Reset      in   1              synchronous, active-high reset
//   ReqValid   in   NUM_REQ        per-requester request valid
//   ReqIn1     in   NUM_REQ*WIDTH  operand A, slice i belongs to requester i
//   ReqIn2     in   NUM_REQ*WIDTH  operand B, slice i belongs to requester i
//   ReqReady   out  NUM_REQ        one-hot grant; transfer = valid & ready
//   RespValid  out  1              output register holds a valid sum
//   RespReady  in   1              consumer takes the response this cycle
//   RespSum    out  WIDTH          registered sum (modulo 2**WIDTH)
//   RespId     out  ID_W           requester index that produced RespSum
//   Busy       out  1              RespValid or any ReqValid high
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WIDTH    operand and sum width
//   ID_W     requester id width, 2**ID_W must be >= NUM_REQ
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// Adder
//
// Purpose:
//   Plain WIDTH-bit combinational adder. The carry-out is dropped on purpose:
//   address arithmetic here wraps modulo 2**WIDTH and nobody needs overflow.
//
// Ports:
//   i_a    in   WIDTH  operand A
//   i_b    in   WIDTH  operand B
//   o_sum  out  WIDTH  i_a + i_b modulo 2**WIDTH
// ---------------------------------------------------------------------------
module Adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum
);

   assign o_sum = i_a + i_b;

endmodule

module adder_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int ID_W    = 2
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [NUM_REQ-1:0]       ReqValid,
   input  logic [NUM_REQ*WIDTH-1:0] ReqIn1,
   input  logic [NUM_REQ*WIDTH-1:0] ReqIn2,
   output logic [NUM_REQ-1:0]       ReqReady,
   output logic                     RespValid,
   input  logic                     RespReady,
   output logic [WIDTH-1:0]         RespSum,
   output logic [ID_W-1:0]          RespId,
   output logic                     Busy
);

   // Registered state: the one-entry response slot and the round-robin
   // pointer naming the requester that currently has highest priority.
   logic              r_respValid;
   logic [WIDTH-1:0]  r_respSum;
   logic [ID_W-1:0]   r_respId;
   logic [ID_W-1:0]   r_ptr;

   // Combinational arbitration and datapath signals.
   logic              w_slotFree;
   logic              w_winValid;
   logic [ID_W-1:0]   w_winIdx;
   logic              w_transfer;
   logic [NUM_REQ-1:0] w_grant;
   logic [WIDTH-1:0]  w_opA;
   logic [WIDTH-1:0]  w_opB;
   logic [WIDTH-1:0]  w_sum;
   logic [ID_W-1:0]   w_nextPtr;

   // The slot can accept a new sum when it is empty, or when the current
   // sum is leaving this very cycle. That pass-through case is what allows
   // one sum per cycle under continuous RespReady.
   assign w_slotFree = ~r_respValid | RespReady;

   // Round-robin search: look at r_ptr, r_ptr+1, ... wrapping at NUM_REQ.
   // The loop walks the offsets from the far end down to zero so the last
   // write wins, which leaves the candidate closest to r_ptr as the winner.
   // Only ReqValid and r_ptr feed this search; operands never influence
   // who gets the grant.
   always_comb begin
      int idx;
      idx        = 0;
      w_winValid = 1'b0;
      w_winIdx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(r_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (ReqValid[idx]) begin
            w_winValid = 1'b1;
            w_winIdx   = ID_W'(idx);
         end
      end
   end

   // A transfer happens only when there is a winner, the slot can take it,
   // and we are not in reset. Reset forces the grant vector to zero so no
   // requester believes it was accepted during a reset cycle.
   assign w_transfer = ~Reset & w_slotFree & w_winValid;

   // Expand the winner index into the one-hot ReqReady vector.
   always_comb begin
      w_grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_grant[i] = w_transfer && (w_winIdx == ID_W'(i));
      end
   end

   assign ReqReady = w_grant;

   // Operand mux in front of the shared adder. Only the winner's slices are
   // forwarded; when nobody wins the mux still selects slot w_winIdx (zero),
   // which is harmless because the sum is not captured without a transfer.
   always_comb begin
      w_opA = '0;
      w_opB = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winIdx == ID_W'(i)) begin
            w_opA = ReqIn1[i*WIDTH +: WIDTH];
            w_opB = ReqIn2[i*WIDTH +: WIDTH];
         end
      end
   end

   Adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .i_a   (w_opA),
      .i_b   (w_opB),
      .o_sum (w_sum)
   );

   // After a grant the winner drops to lowest priority: the pointer moves to
   // the requester just after it, wrapping from NUM_REQ-1 back to 0.
   assign w_nextPtr = (w_winIdx == ID_W'(NUM_REQ - 1)) ? '0
                                                         : w_winIdx + ID_W'(1);

   // Response slot and pointer update. A transfer always loads the slot
   // (it may overwrite a sum that is draining in the same cycle). Without a
   // transfer, a consumed sum empties the slot; a stalled sum simply holds,
   // and the pointer only ever moves on a transfer so idle cycles do not
   // shift priority. Reset drops any pending response outright.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_respValid <= 1'b0;
         r_respSum   <= '0;
         r_respId    <= '0;
         r_ptr       <= '0;
      end else begin
         if (w_transfer) begin
            r_respValid <= 1'b1;
            r_respSum   <= w_sum;
            r_respId    <= w_winIdx;
            r_ptr       <= w_nextPtr;
         end else if (r_respValid && RespReady) begin
            r_respValid <= 1'b0;
         end
      end
   end

   assign RespValid = r_respValid;
   assign RespSum   = r_respSum;
   assign RespId    = r_respId;

   // Busy tells upstream control that either a sum is still waiting to be
   // consumed or some requester is still asking for the adder.
   assign Busy = r_respValid | (|ReqValid);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Purpose:
//   Self-checking bench for adder_share_arbiter (NUM_REQ=4, WIDTH=32).
//   A behavioural model tracks the response slot and the rotating priority
//   and a compare process checks every DUT output on each falling edge.
//   Directed scenarios add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_adder_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int IDW  = 2;

   logic                clock;
   logic                reset;
   logic [NREQ-1:0]     reqValid;
   logic [NREQ*W-1:0]   reqIn1;
   logic [NREQ*W-1:0]   reqIn2;
   logic [NREQ-1:0]     reqReady;
   logic                respValid;
   logic                respReady;
   logic [W-1:0]        respSum;
   logic [IDW-1:0]      respId;
   logic                busy;

   int total = 0;
   int bad   = 0;

   // Model state: whether a sum is held, what it is, who made it, and which
   // requester has top priority right now.
   bit          mInit      = 1'b0;
   bit          mRespValid = 1'b0;
   logic [31:0] mRespSum   = '0;
   int          mRespId    = 0;
   int          mPtr       = 0;

   adder_share_arbiter #(
      .NUM_REQ (NREQ),
      .WIDTH   (W),
      .ID_W    (IDW)
   ) dut (
      .Clk       (clock),
      .Reset     (reset),
      .ReqValid  (reqValid),
      .ReqIn1    (reqIn1),
      .ReqIn2    (reqIn2),
      .ReqReady  (reqReady),
      .RespValid (respValid),
      .RespReady (respReady),
      .RespSum   (respSum),
      .RespId    (respId),
      .Busy      (busy)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One comparison: counts it, and reports a FAIL line on a difference.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
      reqValid  = valid;
      respReady = ready;
   endtask

   task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b);
      reqIn1[i*W +: W] = a;
      reqIn2[i*W +: W] = b;
   endtask

   // Inputs change 1 time unit after the rising edge, well away from it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Who wins this cycle under the rules: nobody while a sum is stalled,
   // otherwise the first valid requester counting upward from mPtr.
   function automatic int modelGrant();
      if (mRespValid && !respReady) return -1;
      for (int k = 0; k < NREQ; k++) begin
         if (reqValid[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [31:0] modelSum(input int i);
      return reqIn1[i*W +: W] + reqIn2[i*W +: W];
   endfunction

   function automatic logic [NREQ-1:0] expReady();
      int g;
      g = modelGrant();
      if (reset || g < 0) return '0;
      return NREQ'(1) << g;
   endfunction

   // Model advance on each rising edge.
   always @(posedge clock) begin
      if (reset) begin
         mInit      <= 1'b1;
         mRespValid <= 1'b0;
         mRespSum   <= '0;
         mRespId    <= 0;
         mPtr       <= 0;
      end else if (mInit) begin
         if (modelGrant() >= 0) begin
            mRespValid <= 1'b1;
            mRespSum   <= modelSum(modelGrant());
            mRespId    <= modelGrant();
            mPtr       <= (modelGrant() + 1) % NREQ;
         end else if (mRespValid && respReady) begin
            mRespValid <= 1'b0;
         end
      end
   end

   // Compare process: every falling edge once the model is initialised.
   always @(negedge clock) begin
      if (mInit) begin
         checkOutput("ReqReady", 32'(reqReady), 32'(expReady()));
         checkOutput("RespValid", 32'(respValid), 32'(mRespValid));
         checkOutput("Busy", 32'(busy), 32'(mRespValid | (|reqValid)));
         if (mRespValid) begin
            checkOutput("RespSum", respSum, mRespSum);
            checkOutput("RespId", 32'(respId), 32'(mRespId));
         end
      end
   end

   initial begin
      reset    = 1'b1;
      reqIn1   = '0;
      reqIn2   = '0;
      applyStimulus(4'b1111, 1'b1);
      for (int i = 0; i < NREQ; i++) setReq(i, 32'h0000_0100 * i, 32'h10 + i);

      // Reset with every request asserted: nothing may be granted.
      step();
      step();
      @(negedge clock);
      checkOutput("rst_ReqReady", 32'(reqReady), 32'h0);
      checkOutput("rst_RespValid", 32'(respValid), 32'h0);
      checkOutput("rst_RespSum", respSum, 32'h0);
      checkOutput("rst_RespId", 32'(respId), 32'h0);
      step();
      reset = 1'b0;

      // First cycle out of reset grants req0.
      @(negedge clock);
      checkOutput("t1_grant0", 32'(reqReady), 32'h1);
      step();
      applyStimulus(4'b1110, 1'b1);
      @(negedge clock);
      checkOutput("t1_RespValid", 32'(respValid), 32'h1);
      checkOutput("t1_RespId", 32'(respId), 32'h0);
      checkOutput("t1_RespSum", respSum, 32'h0000_0010);
      checkOutput("t1_grant1", 32'(reqReady), 32'h2);
      step();
      applyStimulus(4'b0000, 1'b1);
      step();
      step();

      // Single request from req2.
      setReq(2, 32'h0040_0000, 32'h0000_0004);
      applyStimulus(4'b0100, 1'b1);
      @(negedge clock);
      checkOutput("t2_ReqReady", 32'(reqReady), 32'h4);
      step();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clock);
      checkOutput("t2_RespValid", 32'(respValid), 32'h1);
      checkOutput("t2_RespSum", respSum, 32'h0040_0004);
      checkOutput("t2_RespId", 32'(respId), 32'h2);
      step();
      @(negedge clock);
      checkOutput("t2_drained", 32'(respValid), 32'h0);

      // Wrap-around sum on req1.
      step();
      setReq(1, 32'hFFFF_FFFF, 32'h0000_0002);
      applyStimulus(4'b0010, 1'b1);
      @(negedge clock);
      checkOutput("t3_ReqReady", 32'(reqReady), 32'h2);
      step();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clock);
      checkOutput("t3_RespSum", respSum, 32'h0000_0001);
      checkOutput("t3_RespId", 32'(respId), 32'h1);
      step();
      @(negedge clock);
      checkOutput("t3_drained", 32'(respValid), 32'h0);

      // Fairness from Ptr=0 with all four requesting continuously.
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) setReq(i, 32'h0000_1000 * i, i);
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         checkOutput("t4_grant", 32'(reqReady), 32'(1 << (k % 4)));
         if (k > 0) checkOutput("t4_RespId", 32'(respId), 32'((k - 1) % 4));
         step();
      end

      // Backpressure: req3's sum is pending, req1/req3 wait.
      applyStimulus(4'b1010, 1'b0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         checkOutput("t5_stallReady", 32'(reqReady), 32'h0);
         checkOutput("t5_stallId", 32'(respId), 32'h3);
         checkOutput("t5_stallSum", respSum, 32'h0000_3003);
         step();
      end
      applyStimulus(4'b1010, 1'b1);
      @(negedge clock);
      checkOutput("t5_passGrant", 32'(reqReady), 32'h2);
      step();
      applyStimulus(4'b1000, 1'b1);
      @(negedge clock);
      checkOutput("t5_RespId1", 32'(respId), 32'h1);
      checkOutput("t5_grant3", 32'(reqReady), 32'h8);
      step();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clock);
      checkOutput("t5_RespId3", 32'(respId), 32'h3);
      step();
      step();

      // Reset in the middle of a stall throws the pending sum away.
      setReq(2, 32'h0000_0200, 32'h0000_0002);
      applyStimulus(4'b0100, 1'b0);
      @(negedge clock);
      checkOutput("t6_grant2", 32'(reqReady), 32'h4);
      step();
      applyStimulus(4'b0000, 1'b0);
      @(negedge clock);
      checkOutput("t6_pending", 32'(respValid), 32'h1);
      checkOutput("t6_pendingId", 32'(respId), 32'h2);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      applyStimulus(4'b1001, 1'b1);
      @(negedge clock);
      checkOutput("t6_flushed", 32'(respValid), 32'h0);
      checkOutput("t6_ptrZero", 32'(reqReady), 32'h1);
      step();
      applyStimulus(4'b1000, 1'b1);
      @(negedge clock);
      checkOutput("t6_newId", 32'(respId), 32'h0);
      step();
      applyStimulus(4'b0000, 1'b1);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
